// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns the parity bit a transmitter should send; zero-extension keeps parity intact.
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        case (mode)
            PAR_ODD:  return ~(^data);
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with 3-sample majority voting, optional parity,
// 1/2 stop bits, a character FIFO and sticky error flags.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst,
    input  logic                          i_Rx_Serial,
    input  logic                          i_Ready,
    output logic                          o_Valid,
    output logic [DATA_BITS-1:0]          o_Data,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    input  logic                          i_Clear_Err,
    output logic                          o_Frame_Err,
    output logic                          o_Parity_Err,
    output logic                          o_Overrun,
    output rx_state_e                     o_State
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_WRAP = CW'(CLKS_PER_BIT - 1);

    rx_state_e            state, state_next;
    logic                 sync1, sync2, rx_s;
    logic                 armed;
    logic [CW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 samp0, samp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_low;
    logic                 at_dec, at_wrap, bit_val;
    logic                 complete;
    logic                 frame_bad, par_bad;
    logic                 push, pop, fifo_full, fifo_empty;

    assign rx_s    = sync2;
    assign at_dec  = (bit_cnt == C_DEC);
    assign at_wrap = (bit_cnt == C_WRAP);
    assign bit_val = majority3(samp0, samp1, rx_s);
    assign o_State = state;

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) state <= RX_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            RX_IDLE:   if (armed && !rx_s) state_next = RX_START;
            RX_START:  if (at_dec && bit_val) state_next = RX_IDLE;
                       else if (at_wrap)      state_next = RX_DATA;
            RX_DATA:   if (at_wrap && bit_idx == BW'(DATA_BITS - 1))
                           state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (at_wrap) state_next = RX_STOP;
            // Finish mid final stop bit so the next start edge is caught promptly.
            RX_STOP:   if (at_dec && stop_idx == 1'(STOP_BITS - 1)) begin
                           state_next = RX_IDLE;
                           complete   = 1'b1;
                       end
            default:   state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            armed    <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            samp0    <= 1'b1;
            samp1    <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_low <= 1'b0;
        end else begin
            sync1 <= i_Rx_Serial;
            sync2 <= sync1;
            if (state != RX_IDLE) armed <= 1'b0;
            else if (rx_s)        armed <= 1'b1;

            if (state == RX_IDLE || state_next != state || at_wrap) bit_cnt <= '0;
            else                                                      bit_cnt <= bit_cnt + 1'b1;

            if (bit_cnt == C_S0) samp0 <= rx_s;
            if (bit_cnt == C_S1) samp1 <= rx_s;

            if (state == RX_START) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop_low <= 1'b0;
            end
            if (state == RX_DATA && at_dec)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state == RX_DATA && at_wrap)  bit_idx <= bit_idx + 1'b1;
            if (state == RX_PARITY && at_dec) par_bit <= bit_val;
            if (state == RX_STOP && at_dec && !bit_val) stop_low <= 1'b1;
            if (state == RX_STOP && at_wrap)  stop_idx <= 1'b1;
        end
    end

    // Commit priority: framing, then parity, then FIFO space.
    assign frame_bad = stop_low || !bit_val;
    assign par_bad   = (PARITY != 0) &&
                       (par_bit != calc_parity(9'(shreg), parity_e'(2'(PARITY))));
    assign pop       = o_Valid && i_Ready;
    assign push      = complete && !frame_bad && !par_bad && (!fifo_full || pop);

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            if (complete && frame_bad)  o_Frame_Err <= 1'b1;
            else if (i_Clear_Err)       o_Frame_Err <= 1'b0;
            if (complete && !frame_bad && par_bad) o_Parity_Err <= 1'b1;
            else if (i_Clear_Err)                  o_Parity_Err <= 1'b0;
            if (complete && !frame_bad && !par_bad && fifo_full && !pop) o_Overrun <= 1'b1;
            else if (i_Clear_Err)                                         o_Overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst   (i_Rst),
        .push  (push),
        .din   (shreg),
        .pop   (pop),
        .dout  (o_Data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_Count)
    );

    assign o_Valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: three instances cover 8N1 at full
// baud divisor, even parity with two stop bits, and a fast 8N1 for FIFO/break/reset.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int CPB_A = 417;
  localparam int CPB_B = 32;
  localparam int CPB_C = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx_a, ready_a, clr_a, valid_a, fe_a, pe_a, ov_a;
  logic rx_b, ready_b, clr_b, valid_b, fe_b, pe_b, ov_b;
  logic rx_c, ready_c, clr_c, valid_c, fe_c, pe_c, ov_c;
  logic [7:0] data_a, data_b, data_c;
  logic [4:0] count_a, count_b;
  logic [2:0] count_c;
  rx_state_e st_a, st_b, st_c;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .i_Clock(clk), .i_Rst(rst), .i_Rx_Serial(rx_a), .i_Ready(ready_a), .o_Valid(valid_a),
    .o_Data(data_a), .o_Count(count_a), .i_Clear_Err(clr_a), .o_Frame_Err(fe_a),
    .o_Parity_Err(pe_a), .o_Overrun(ov_a), .o_State(st_a));

  uart_rx_buffered #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
    .i_Clock(clk), .i_Rst(rst), .i_Rx_Serial(rx_b), .i_Ready(ready_b), .o_Valid(valid_b),
    .o_Data(data_b), .o_Count(count_b), .i_Clear_Err(clr_b), .o_Frame_Err(fe_b),
    .o_Parity_Err(pe_b), .o_Overrun(ov_b), .o_State(st_b));

  uart_rx_buffered #(.CLKS_PER_BIT(CPB_C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_Clock(clk), .i_Rst(rst), .i_Rx_Serial(rx_c), .i_Ready(ready_c), .o_Valid(valid_c),
    .o_Data(data_c), .o_Count(count_c), .i_Clear_Err(clr_c), .o_Frame_Err(fe_c),
    .o_Parity_Err(pe_c), .o_Overrun(ov_c), .o_State(st_c));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pop_a[$], pop_b[$], pop_c[$];
  logic [7:0] exp_q[$];

  // Every accepted pop is logged, away from the active edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) pop_a.push_back(data_a);
    if (valid_b && ready_b) pop_b.push_back(data_b);
    if (valid_c && ready_c) pop_c.push_back(data_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_ready(input int idx, input logic v);
    case (idx)
      0:       ready_a = v;
      1:       ready_b = v;
      default: ready_c = v;
    endcase
  endtask

  // par_mode: 0 none, 1 odd, 2 even; last_stop is the level of the final stop bit.
  task automatic send_frame(input int idx, input int clks, input logic [7:0] d,
                            input int par_mode, input logic par_flip,
                            input int nstop, input logic last_stop);
    logic p;
    set_line(idx, 1'b0);
    repeat (clks) tick();
    for (int i = 0; i < 8; i++) begin
      set_line(idx, d[i]);
      repeat (clks) tick();
    end
    if (par_mode != 0) begin
      p = (par_mode == 1) ? ~(^d) : ^d;
      set_line(idx, p ^ par_flip);
      repeat (clks) tick();
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(idx, (s == nstop - 1) ? last_stop : 1'b1);
      repeat (clks) tick();
    end
    set_line(idx, 1'b1);
  endtask

  task automatic drain(input int idx, input int n);
    int got;
    set_ready(idx, 1'b1);
    for (int c = 0; c < 4 * n + 8; c++) begin
      tick();
      got = (idx == 0) ? pop_a.size() : (idx == 1) ? pop_b.size() : pop_c.size();
      if (got >= n) break;
    end
    set_ready(idx, 1'b0);
  endtask

  task automatic check_pops(input string tag, input int idx);
    logic [7:0] got[$];
    logic [31:0] obs;
    case (idx)
      0:       begin got = pop_a; pop_a.delete(); end
      1:       begin got = pop_b; pop_b.delete(); end
      default: begin got = pop_c; pop_c.delete(); end
    endcase
    check({tag, "_n"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
      check($sformatf("%s_%0d", tag, i), obs, 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", valid_a, 0);
    check("rst_count", count_a, 0);
    check("rst_data",  data_a,  0);
    check("rst_flags", {fe_a, pe_a, ov_a}, 0);
    check("rst_state", 32'(st_a), 32'(RX_IDLE));
    rst = 1'b0;
    repeat (5) tick();

    // 1: single 8N1 character with the consumer always ready
    ready_a = 1'b1;
    send_frame(0, CPB_A, 8'h41, 0, 1'b0, 1, 1'b1);
    repeat (CPB_A) tick();
    ready_a = 1'b0;
    exp_q = '{8'h41};
    check_pops("t1_pop", 0);
    check("t1_flags", {fe_a, pe_a, ov_a}, 0);
    check("t1_count", count_a, 0);

    // 2: back-to-back "Hi~" buffered, then drained in order
    send_frame(0, CPB_A, 8'h48, 0, 1'b0, 1, 1'b1);
    send_frame(0, CPB_A, 8'h69, 0, 1'b0, 1, 1'b1);
    send_frame(0, CPB_A, 8'h7E, 0, 1'b0, 1, 1'b1);
    repeat (CPB_A) tick();
    check("t2_count", count_a, 3);
    check("t2_valid", valid_a, 1);
    check("t2_head",  data_a, 8'h48);
    drain(0, 3);
    exp_q = '{8'h48, 8'h69, 8'h7E};
    check_pops("t2_pop", 0);
    check("t2_count_empty", count_a, 0);

    // 4: short low glitch is rejected, then a real character follows
    set_line(0, 1'b0);
    repeat (150) tick();
    set_line(0, 1'b1);
    repeat (3 * CPB_A) tick();
    check("t4_count", count_a, 0);
    check("t4_flags", {fe_a, pe_a, ov_a}, 0);
    check("t4_state", 32'(st_a), 32'(RX_IDLE));
    ready_a = 1'b1;
    send_frame(0, CPB_A, 8'h3C, 0, 1'b0, 1, 1'b1);
    repeat (CPB_A) tick();
    ready_a = 1'b0;
    exp_q = '{8'h3C};
    check_pops("t4_pop", 0);

    // 3: even parity, two stop bits
    send_frame(2, CPB_C, 8'h55, 2, 1'b1, 2, 1'b1);
    repeat (CPB_C) tick();
    check("t3_perr", pe_c, 1);
    check("t3_ferr0", fe_c, 0);
    check("t3_count0", count_c, 0);
    send_frame(2, CPB_C, 8'h55, 2, 1'b0, 2, 1'b1);
    repeat (CPB_C) tick();
    check("t3_count1", count_c, 1);
    check("t3_head", data_c, 8'h55);
    check("t3_perr_sticky", pe_c, 1);
    send_frame(2, CPB_C, 8'h0F, 2, 1'b0, 2, 1'b0);
    repeat (CPB_C) tick();
    check("t3_ferr_stop2", fe_c, 1);
    check("t3_count_after_ferr", count_c, 1);
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    tick();
    check("t3_clear", {fe_c, pe_c, ov_c}, 0);
    drain(2, 1);
    exp_q = '{8'h55};
    check_pops("t3_pop", 2);

    // 5: seventeen characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(1, CPB_B, 8'(i), 0, 1'b0, 1, 1'b1);
    repeat (CPB_B) tick();
    check("t5_count", count_b, 16);
    check("t5_overrun", ov_b, 1);
    check("t5_other_flags", {fe_b, pe_b}, 0);
    check("t5_head", data_b, 8'h00);
    drain(1, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_pops("t5_pop", 1);
    check("t5_count_empty", count_b, 0);

    // 6: break, recovery, then reset in the middle of a frame
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    tick();
    check("t6_ovr_cleared", ov_b, 0);
    set_line(1, 1'b0);
    repeat (30 * CPB_B) tick();
    set_line(1, 1'b1);
    repeat (2 * CPB_B) tick();
    check("t6_break_ferr", fe_b, 1);
    check("t6_break_count", count_b, 0);
    check("t6_break_perr", pe_b, 0);
    send_frame(1, CPB_B, 8'hA5, 0, 1'b0, 1, 1'b1);
    repeat (CPB_B) tick();
    check("t6_a5_count", count_b, 1);
    check("t6_a5_head", data_b, 8'hA5);
    set_line(1, 1'b0);
    repeat (CPB_B) tick();
    set_line(1, 1'b1);
    repeat (CPB_B) tick();
    set_line(1, 1'b0);
    repeat (CPB_B / 2) tick();
    rst = 1'b1;
    set_line(1, 1'b1);
    repeat (3) tick();
    check("t6_rst_valid", valid_b, 0);
    check("t6_rst_count", count_b, 0);
    check("t6_rst_data", data_b, 0);
    check("t6_rst_flags", {fe_b, pe_b, ov_b}, 0);
    check("t6_rst_state", 32'(st_b), 32'(RX_IDLE));
    rst = 1'b0;
    repeat (10 * CPB_B) tick();
    check("t6_post_rst_count", count_b, 0);
    ready_b = 1'b1;
    send_frame(1, CPB_B, 8'h96, 0, 1'b0, 1, 1'b1);
    repeat (CPB_B) tick();
    ready_b = 1'b0;
    exp_q = '{8'h96};
    check_pops("t6_pop", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
